// File: rtl/bram_dump_reader_pkg.sv
// Shared types and constants for the bram32 debug-port dump engine.
package bram_dump_reader_pkg;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_READ = 2'd1,
    DUMP_HOLD = 2'd2
  } dump_state_t;

  localparam int DUMP_ADDR_STEP = 4;

endpackage

// File: rtl/bram_dump_reader.sv
// Walks a contiguous word range through the bram32 debug read port and
// streams each word with its byte address over a valid/ready interface.
module bram_dump_reader
  import bram_dump_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] word_count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] debug_addr,
  input  logic [DATA_WIDTH-1:0] debug_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DUMP_ADDR_STEP);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);
  localparam logic [0:0]            LAT_LAST  = 1'(RD_LAT);

  dump_state_t           state;
  dump_state_t           next_state;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [0:0]            lat_cnt;
  logic                  read_done;

  // The read phase ends once the debug port has had RD_LAT extra clocks.
  assign read_done = (lat_cnt == LAT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DUMP_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // abort wins over a simultaneous handshake, so the beat is dropped
  always_comb begin
    next_state = state;
    m_valid    = 1'b0;
    busy       = 1'b0;
    case (state)
      DUMP_IDLE: begin
        if (start && (word_count != '0)) begin
          next_state = DUMP_READ;
        end
      end
      DUMP_READ: begin
        busy = 1'b1;
        if (abort) begin
          next_state = DUMP_IDLE;
        end else if (read_done) begin
          next_state = DUMP_HOLD;
        end
      end
      DUMP_HOLD: begin
        busy    = 1'b1;
        m_valid = 1'b1;
        if (abort) begin
          next_state = DUMP_IDLE;
        end else if (m_ready) begin
          next_state = m_last ? DUMP_IDLE : DUMP_READ;
        end
      end
      default: begin
        next_state = DUMP_IDLE;
      end
    endcase
  end

  // debug_addr doubles as the walking address and holds its value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      debug_addr <= '0;
      remaining  <= '0;
      lat_cnt    <= '0;
      m_data     <= '0;
      m_addr     <= '0;
      m_last     <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        DUMP_IDLE: begin
          if (start) begin
            debug_addr <= base_addr & ADDR_MASK;
            remaining  <= word_count;
            lat_cnt    <= '0;
            done       <= (word_count == '0);
          end
        end
        DUMP_READ: begin
          if (abort) begin
            lat_cnt <= '0;
            m_last  <= 1'b0;
          end else if (read_done) begin
            m_data  <= debug_data;
            m_addr  <= debug_addr;
            m_last  <= (remaining == ADDR_WIDTH'(1));
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        DUMP_HOLD: begin
          if (abort) begin
            m_last <= 1'b0;
          end else if (m_ready) begin
            if (m_last) begin
              m_last <= 1'b0;
              done   <= 1'b1;
            end else begin
              debug_addr <= debug_addr + ADDR_STEP;
              remaining  <= remaining - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/bram_dump_reader.md
Name: bram_dump_reader

Overview:
Read-side engine for the bram32 debug read port. After a program runs, it walks a contiguous word range of data or instruction BRAM and streams each word out over a valid/ready interface, together with its byte address. Benches and the future UART/host dump path use it to extract memory contents instead of poking debug_addr by hand. It never writes to memory, and the CPU datapath is untouched.

Parameters:
ADDR_WIDTH, 10, byte-address width of the BRAM debug port
DATA_WIDTH, 32, word width; always `DATA_WIDTH
RD_LAT, 0, debug-port read latency in clocks. 0 = combinational read (current bram32), 1 = registered read. Other values are illegal.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a dump; sampled only in IDLE
base_addr  in  ADDR_WIDTH  byte address of first word; bits [1:0] ignored (treated as 0)
word_count  in  ADDR_WIDTH  number of words to dump; 0 is legal
abort  in  1  cancel the dump in progress
debug_addr  out  ADDR_WIDTH  drives bram32 debug_addr
debug_data  in  DATA_WIDTH  from bram32 debug_data
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts the word
m_data  out  DATA_WIDTH  captured word
m_addr  out  ADDR_WIDTH  byte address of m_data
m_last  out  1  high with m_valid on the final word
busy  out  1  high from start acceptance until completion or abort
done  out  1  one-cycle pulse on normal completion

Behaviour:
- Reset (rst=1 at a clock edge) overrides everything and returns to IDLE.
  - All outputs go to 0, including debug_addr.
  - The word counter and latency counter clear.
- States:
  - IDLE: busy=0, m_valid=0.
  - READ: debug_addr = current address. Lasts exactly 1+RD_LAT cycles (latency counter). On the last cycle, debug_data is captured into m_data, current address into m_addr, and m_last = (remaining==1). Transition to HOLD.
  - HOLD: m_valid=1. m_data, m_addr and m_last are held stable until the handshake.
- Start: IDLE with start=1 at edge E0 latches base_addr (low 2 bits zeroed) and word_count.
  - word_count!=0: go to READ, busy=1.
  - word_count==0: stay IDLE, done=1 for the cycle after E0, busy stays 0, no beats.
- start is ignored whenever busy=1.
- Latency: m_valid first rises 1+RD_LAT clocks after E0.
- Handshake: a beat transfers on an edge where m_valid&&m_ready.
  - Not last: address += 4, remaining -= 1, m_valid drops, go to READ.
  - Last: go to IDLE, busy drops, done=1 for exactly one cycle.
- Throughput: at most one word per 2+RD_LAT cycles. m_valid never rises in the same cycle that a handshake completes.
- m_ready may be held low indefinitely in HOLD; outputs must not change.
- Address wrap-around: address arithmetic is mod 2^ADDR_WIDTH. After 0x3FC the next address is 0x000, with no error.
- abort=1 at an edge while busy:
  - Return to IDLE next cycle; m_valid, m_last and busy go to 0.
  - No done pulse.
  - abort takes priority over a simultaneous handshake, so that beat counts as not transferred.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: abort is ignored and start is accepted.
- Reset mid-dump: immediate return to IDLE; no done pulse.
- debug_addr holds its last value in IDLE (no combinational glitching required).

Decomposition:
- Add to rv32i_params.vh:
  - state encodings DUMP_IDLE=2'd0, DUMP_READ=2'd1, DUMP_HOLD=2'd2;
  - `DUMP_ADDR_STEP = 4;
  - `DATA_WIDTH is reused.
- Single module; no sub-module is natural. The latency counter and word counter are inline registers.
- An 11-bit remaining counter is not required: a 10-bit counter suffices because word_count ≤ 1023.

Test Plan:
1. Preload data BRAM 0x0=00000005, 0x4=00000006, 0x8=00000001, 0xC=00000001; base=0x0, count=4, m_ready=1 -> four beats with (addr,data): (000,00000005), (004,00000006), (008,00000001), (00C,00000001). m_last on beat 4 only; done pulses once; busy low afterwards.
2. Same as 1 with m_ready low for 5 cycles on beat 2 -> m_valid stays high; m_data=00000006 and m_addr=004 are stable throughout; the sequence is otherwise identical.
3. base=0x3F8, count=3, memory 0x3F8=AAAA0001, 0x3FC=AAAA0002, 0x000=AAAA0003 -> beats at 3F8, 3FC, 000 with those data; m_last on 000.
4. count=0, start=1 -> no m_valid ever; done=1 the cycle after start; busy remains 0.
5. count=4; assert abort during HOLD of beat 2 together with m_ready=1 -> returns to IDLE, no done, only beat 1 counted. A new start with base=0x8, count=1 then yields a single beat (008,00000001) with m_last=1.
6. RD_LAT=1 build with a registered-read memory model; repeat scenario 1 -> identical data. First m_valid rises 2 clocks after the start edge; beat spacing is ≥3 cycles.
